// File: rtl/fpcvt_pkg.sv
// Shared constants, stage payload types and width check for the fpcvt pipeline.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package fpcvt_pkg;
    localparam int FP_DW = 13;
    localparam int FP_EW = 3;
    localparam int FP_MW = 5;
    localparam int EMAX  = (1 << FP_EW) - 1;
    localparam int LZW   = $clog2(FP_DW);

    typedef struct packed {
        logic              s;
        logic              fsat;
        logic [FP_DW-2:0]  mag;
    } s1_t;

    typedef struct packed {
        logic              s;
        logic              fsat;
        logic [FP_EW-1:0]  e;
        logic [FP_MW-1:0]  f;
        logic              r;
`ifdef FPCVT_RNE_EN
        logic              sticky;
`endif
    } s2_t;

    function automatic bit fpcvt_widths_ok(input int dw, input int ew, input int mw);
        return dw == mw + (1 << ew);
    endfunction
endpackage

// File: rtl/fpcvt_lzc.sv
// Leading-zero counter; an all-zero input returns W.
// Latency: combinational.
// Backpressure: none.
module fpcvt_lzc #(
    parameter int W   = 12,
    parameter int LZW = 4
) (
    input  logic [W-1:0]   a_i,
    output logic [LZW-1:0] lz_o
);
    // Scan upwards so the highest set bit has the last word.
    always_comb begin
        lz_o = LZW'(W);
        for (int i = 0; i < W; i++) begin
            if (a_i[i]) lz_o = LZW'(W - 1 - i);
        end
    end
endmodule

// File: rtl/fpcvt_pipe.sv
// Integer to sign/exponent/significand converter with saturation (FPCVT_RNE_EN selects round-to-nearest-even).
// Latency: 3 cycles, 1 sample/cycle.
// Backpressure: bubble-collapsing valid/ready; in_ready = ~v1 | adv1, output held while out_ready is low.
module fpcvt_pipe
    import fpcvt_pkg::*;
#(
    parameter int DW = FP_DW,
    parameter int EW = FP_EW,
    parameter int MW = FP_MW,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_s,
    output logic [EW-1:0] out_e,
    output logic [MW-1:0] out_f,
    output logic          out_sat,
    input  logic          clr_cnt,
    output logic [CW-1:0] sat_cnt
);
    // Stage payloads are sized in fpcvt_pkg, so overrides must agree with it.
    if (!fpcvt_widths_ok(DW, EW, MW) || DW != FP_DW || EW != FP_EW || MW != FP_MW) begin : g_bad_width
        $error("fpcvt_pipe: DW must equal MW + 2**EW and match fpcvt_pkg");
    end

    logic          v1_q, v2_q, v3_q;
    logic          ld1, ld2, ld3;
    s1_t           s1_d, s1_q;
    s2_t           s2_d, s2_q;
    logic          out_s_q, out_sat_q;
    logic [EW-1:0] out_e_q;
    logic [MW-1:0] out_f_q;
    logic [CW-1:0] sat_cnt_q;
    logic [LZW-1:0] lz;
    logic          inc, sat;
    logic [MW:0]   fsum;
    logic [EW:0]   esum;

    assign ld3      = ~v3_q | out_ready;
    assign ld2      = ~v2_q | ld3;
    assign ld1      = ~v1_q | ld2;
    assign in_ready = ld1;

    always_comb begin
        s1_d      = '0;
        s1_d.s    = in_data[DW-1];
        s1_d.mag  = in_data[DW-1] ? (~in_data[DW-2:0] + 1'b1) : in_data[DW-2:0];
        s1_d.fsat = in_data[DW-1] & ~(|in_data[DW-2:0]);
    end

    fpcvt_lzc #(.W(DW - 1), .LZW(LZW)) u_lzc (
        .a_i  (s1_q.mag),
        .lz_o (lz)
    );

    // Left-justify {mag,0}: the leading 1 lands at bit DW-1, F and r sit directly below it.
    always_comb begin
        s2_d      = '0;
        s2_d.s    = s1_q.s;
        s2_d.fsat = s1_q.fsat;
        if (lz <= LZW'(EMAX)) begin
            s2_d.e = EW'(EMAX) - EW'(lz);
            {s2_d.f, s2_d.r} = (MW + 1)'(({s1_q.mag, 1'b0} << lz) >> (DW - 1 - MW));
`ifdef FPCVT_RNE_EN
            s2_d.sticky = |((DW - 1 - MW)'({s1_q.mag, 1'b0} << lz));
`endif
        end else begin
            s2_d.f = s1_q.mag[MW-1:0];
        end
    end

    always_comb begin
`ifdef FPCVT_RNE_EN
        inc = s2_q.r & (s2_q.sticky | s2_q.f[0]);
`else
        inc = s2_q.r;
`endif
        fsum = {1'b0, s2_q.f} + {{MW{1'b0}}, inc};
        esum = {1'b0, s2_q.e} + {{EW{1'b0}}, fsum[MW]};
        sat  = esum[EW] | s2_q.fsat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            v3_q      <= 1'b0;
            s1_q      <= '0;
            s2_q      <= '0;
            out_s_q   <= 1'b0;
            out_e_q   <= '0;
            out_f_q   <= '0;
            out_sat_q <= 1'b0;
        end else begin
            if (ld1) begin
                v1_q <= in_valid;
                if (in_valid) s1_q <= s1_d;
            end
            if (ld2) begin
                v2_q <= v1_q;
                if (v1_q) s2_q <= s2_d;
            end
            if (ld3) begin
                v3_q <= v2_q;
                if (v2_q) begin
                    out_s_q   <= s2_q.s;
                    out_sat_q <= sat;
                    out_e_q   <= sat ? '1 : esum[EW-1:0];
                    out_f_q   <= sat ? '1 : (fsum[MW] ? {1'b1, {(MW-1){1'b0}}} : fsum[MW-1:0]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            sat_cnt_q <= '0;
        end else if (v3_q && out_ready && out_sat_q && !(&sat_cnt_q)) begin
            sat_cnt_q <= sat_cnt_q + 1'b1;
        end
    end

    assign out_valid = v3_q;
    assign out_s     = out_s_q;
    assign out_e     = out_e_q;
    assign out_f     = out_f_q;
    assign out_sat   = out_sat_q;
    assign sat_cnt   = sat_cnt_q;
endmodule

// File: tb/tb_fpcvt_pipe.sv
// Scoreboard bench for fpcvt_pipe: expected {s,e,f,sat} queued on input transfer, popped on output transfer.
module tb_fpcvt_pipe;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic        out_s, out_sat, clr_cnt;
    logic [12:0] in_data;
    logic [2:0]  out_e;
    logic [4:0]  out_f;
    logic [7:0]  sat_cnt;

    int          nchk = 0;
    int          nerr = 0;
    logic [9:0]  sb[$];
    logic        obs_xfer, obs_in_rdy, obs_ovld;
    logic [9:0]  obs_val;
    logic [7:0]  obs_cnt;

    logic [12:0] tin  [0:10] = '{13'h006C, 13'h006D, 13'h006E, 13'h006F, 13'h00FD, 13'h003F,
                                 13'h1E5A, 13'h1FFF, 13'h1000, 13'h0FEA, 13'h1007};
    logic [9:0]  texp [0:10] = '{10'b0_010_11011_0, 10'b0_010_11011_0, 10'b0_010_11100_0,
                                 10'b0_010_11100_0, 10'b0_100_10000_0, 10'b0_010_10000_0,
                                 10'b1_100_11010_0, 10'b1_000_00001_0, 10'b1_111_11111_1,
                                 10'b0_111_11111_1, 10'b1_111_11111_1};

    always #5 clk = ~clk;

    fpcvt_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s), .out_e(out_e),
        .out_f(out_f), .out_sat(out_sat), .clr_cnt(clr_cnt), .sat_cnt(sat_cnt)
    );

    // Reference: integer magnitude, explicit remainder-based rounding.
    function automatic logic [9:0] model(input logic [12:0] d);
        int v, a, p, sh, f, rem, half;
        logic s, inc;
        s = d[12];
        v = s ? int'(d) - 8192 : int'(d);
        a = s ? -v : v;
        if (a < 32) return {s, 3'b000, a[4:0], 1'b0};
        p = 0;
        for (int i = 0; i < 14; i++) if (a >= (1 << i)) p = i;
        sh   = p - 4;
        f    = a >> sh;
        rem  = a - (f << sh);
        half = 1 << (sh - 1);
`ifdef FPCVT_RNE_EN
        inc = (rem > half) || (rem == half && f[0]);
`else
        inc = rem >= half;
`endif
        if (inc) f = f + 1;
        if (f == 32) begin f = 16; sh = sh + 1; end
        if (sh > 7) return {s, 3'b111, 5'b11111, 1'b1};
        return {s, sh[2:0], f[4:0], 1'b0};
    endfunction

    task automatic step(input logic vld, input logic [12:0] d, input logic [9:0] exp,
                        input logic ordy, input logic clr, output logic acc);
        in_valid = vld; in_data = d; out_ready = ordy; clr_cnt = clr;
        @(negedge clk);
        acc        = vld & in_ready;
        obs_in_rdy = in_ready;
        obs_ovld   = out_valid;
        obs_xfer   = out_valid & out_ready;
        obs_val    = {out_s, out_e, out_f, out_sat};
        obs_cnt    = sat_cnt;
        if (acc) sb.push_back(exp);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; clr_cnt = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nchk++;
        if (out_valid !== 1'b0 || {out_s, out_e, out_f, out_sat} !== 10'd0 || sat_cnt !== 8'd0) begin
            nerr++;
            $display("FAIL reset_state: vld=%b out=%b cnt=%0d, need 0/0/0", out_valid, {out_s, out_e, out_f, out_sat}, sat_cnt);
        end
        nchk++;
        if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready: got %b need 1", in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [12:0] d[3];
        logic [9:0]  ex[3];
        logic [9:0]  e;
        logic        acc;
        int          k;
        d = '{13'd0, 13'd2, 13'd31};
        ex = '{10'b0_000_00000_0, 10'b0_000_00010_0, 10'b0_000_11111_0};
        k = 0;
        for (int i = 0; i < 10; i++) begin
            if (i < 3) step(1'b1, d[i], ex[i], 1'b1, 1'b0, acc);
            else       step(1'b0, 13'd0, 10'd0, 1'b1, 1'b0, acc);
            if (i < 3) begin
                nchk++;
                if (obs_in_rdy !== 1'b1) begin nerr++; $display("FAIL b2b_in_ready: cycle %0d got %b need 1", i, obs_in_rdy); end
            end
            if (obs_xfer) begin
                nchk++;
                if (i != 3 + k) begin nerr++; $display("FAIL b2b_latency: result %0d at cycle %0d need %0d", k, i, 3 + k); end
                nchk++;
                if (sb.size() == 0) begin nerr++; $display("FAIL b2b_data: unexpected output %b", obs_val); end
                else begin
                    e = sb.pop_front();
                    if (obs_val !== e) begin nerr++; $display("FAIL b2b_data: got %b need %b", obs_val, e); end
                end
                k++;
            end
        end
        nchk++;
        if (k != 3 || sb.size() != 0) begin nerr++; $display("FAIL b2b_count: got %0d outputs need 3, %0d left", k, sb.size()); end
    endtask

    task automatic test_table();
        logic [9:0] e;
        logic       acc;
        logic [7:0] c0;
        c0 = sat_cnt;
        for (int i = 0; i < 18; i++) begin
            if (i < 11) step(1'b1, tin[i], texp[i], 1'b1, 1'b0, acc);
            else        step(1'b0, 13'd0, 10'd0, 1'b1, 1'b0, acc);
            if (obs_xfer) begin
                nchk++;
                if (sb.size() == 0) begin nerr++; $display("FAIL table_data: unexpected output %b", obs_val); end
                else begin
                    e = sb.pop_front();
                    if (obs_val !== e) begin nerr++; $display("FAIL table_data: got %b need %b", obs_val, e); end
                end
            end
        end
        nchk++;
        if (sb.size() != 0) begin nerr++; $display("FAIL table_drain: %0d results missing", sb.size()); end
        nchk++;
        if (sat_cnt !== c0 + 8'd3) begin nerr++; $display("FAIL table_sat_cnt: got %0d need %0d", sat_cnt, c0 + 8'd3); end
    endtask

    task automatic test_backpressure();
        logic [12:0] s[4];
        logic [9:0]  e;
        logic        acc;
        int          idx;
        for (int i = 0; i < 4; i++) s[i] = 13'($urandom);
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            step(1'b1, s[idx], model(s[idx]), 1'b0, 1'b0, acc);
            if (acc) idx++;
            if (c >= 3) begin
                nchk++;
                if (obs_in_rdy !== 1'b0) begin nerr++; $display("FAIL bp_in_ready: cycle %0d got %b need 0", c, obs_in_rdy); end
                nchk++;
                if (obs_ovld !== 1'b1 || obs_val !== sb[0]) begin
                    nerr++; $display("FAIL bp_hold: cycle %0d vld=%b out=%b need 1/%b", c, obs_ovld, obs_val, sb[0]);
                end
            end
        end
        nchk++;
        if (idx != 3) begin nerr++; $display("FAIL bp_fill: accepted %0d need 3", idx); end
        for (int c = 0; c < 15; c++) begin
            if (idx < 4) begin
                step(1'b1, s[idx], model(s[idx]), 1'b1, 1'b0, acc);
                if (acc) idx++;
            end else step(1'b0, 13'd0, 10'd0, 1'b1, 1'b0, acc);
            if (obs_xfer) begin
                nchk++;
                if (sb.size() == 0) begin nerr++; $display("FAIL bp_data: duplicate output %b", obs_val); end
                else begin
                    e = sb.pop_front();
                    if (obs_val !== e) begin nerr++; $display("FAIL bp_data: got %b need %b", obs_val, e); end
                end
            end
        end
        nchk++;
        if (idx != 4 || sb.size() != 0) begin nerr++; $display("FAIL bp_drain: accepted %0d, %0d missing", idx, sb.size()); end
    endtask

    task automatic test_random();
        logic [12:0] d;
        logic [9:0]  e;
        logic        acc, vld, ordy;
        for (int c = 0; c < 330; c++) begin
            case ($urandom_range(0, 3))
                0:       d = 13'($urandom_range(0, 63));
                1:       d = 13'($urandom_range(13'h0FC0, 13'h1040));
                default: d = 13'($urandom);
            endcase
            vld  = (c < 300) && ($urandom_range(0, 3) != 0);
            ordy = (c >= 300) || ($urandom_range(0, 3) != 0);
            step(vld, d, model(d), ordy, 1'b0, acc);
            if (obs_xfer) begin
                nchk++;
                if (sb.size() == 0) begin nerr++; $display("FAIL rand_data: unexpected output %b", obs_val); end
                else begin
                    e = sb.pop_front();
                    if (obs_val !== e) begin nerr++; $display("FAIL rand_data: got %b need %b", obs_val, e); end
                end
            end
        end
        nchk++;
        if (sb.size() != 0) begin nerr++; $display("FAIL rand_drain: %0d results missing", sb.size()); end
    endtask

    task automatic test_reset_midstream();
        logic acc;
        int   seen;
        for (int i = 0; i < 3; i++) step(1'b1, 13'h1000, 10'b1_111_11111_1, 1'b1, 1'b0, acc);
        rst = 1'b1;
        step(1'b0, 13'd0, 10'd0, 1'b1, 1'b0, acc);
        sb.delete();
        @(negedge clk);
        nchk++;
        if (out_valid !== 1'b0 || sat_cnt !== 8'd0) begin
            nerr++; $display("FAIL midrst_state: vld=%b cnt=%0d need 0/0", out_valid, sat_cnt);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 13'd0, 10'd0, 1'b1, 1'b0, acc);
            if (obs_ovld) seen++;
        end
        nchk++;
        if (seen != 0) begin nerr++; $display("FAIL midrst_stale: %0d stale outputs need 0", seen); end
    endtask

    task automatic test_clr_cnt();
        logic [9:0] e;
        logic       acc;
        for (int i = 0; i < 9; i++) begin
            step(i < 3, 13'h0FEA, 10'b0_111_11111_1, 1'b1, i == 5, acc);
            if (obs_xfer) begin
                nchk++;
                if (sb.size() == 0) begin nerr++; $display("FAIL clr_data: unexpected output %b", obs_val); end
                else begin
                    e = sb.pop_front();
                    if (obs_val !== e) begin nerr++; $display("FAIL clr_data: got %b need %b", obs_val, e); end
                end
            end
            if (i == 5) begin
                nchk++;
                if (!obs_xfer || obs_cnt !== 8'd2) begin
                    nerr++; $display("FAIL clr_setup: xfer=%b cnt=%0d need 1/2", obs_xfer, obs_cnt);
                end
            end
            if (i == 6) begin
                nchk++;
                if (obs_cnt !== 8'd0) begin nerr++; $display("FAIL clr_priority: cnt=%0d need 0", obs_cnt); end
            end
        end
    endtask

    task automatic test_sat_ceiling();
        logic [9:0] e;
        logic       acc;
        for (int i = 0; i < 270; i++) begin
            step(i < 262, 13'h1007, 10'b1_111_11111_1, 1'b1, 1'b0, acc);
            if (obs_xfer) begin
                nchk++;
                if (sb.size() == 0) begin nerr++; $display("FAIL ceil_data: unexpected output %b", obs_val); end
                else begin
                    e = sb.pop_front();
                    if (obs_val !== e) begin nerr++; $display("FAIL ceil_data: got %b need %b", obs_val, e); end
                end
            end
        end
        nchk++;
        if (sat_cnt !== 8'd255) begin nerr++; $display("FAIL ceil_cnt: got %0d need 255", sat_cnt); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_table();
        test_backpressure();
        test_random();
        test_reset_midstream();
        test_clr_cnt();
        test_sat_ceiling();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/fpcvt_pipe.md
Name: fpcvt_pipe

Overview:
- Pipelined, parametrised successor to the 13-bit combinational FP converter.
- Converts a DW-bit two's-complement integer to sign / EW-bit exponent / MW-bit significand floating point, with round-half-up and saturation.
- Three registered stages with a valid/ready handshake on both sides, plus a saturation-event counter.
- Sits between the sample source and any downstream consumer that may stall.

Parameters:
- DW, 13: input width. Must satisfy DW = MW + 2^EW; an elaboration-time check fails otherwise.
- EW, 3: exponent width.
- MW, 5: significand width.
- CW, 8: saturation counter width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample this cycle
- in_data  in  DW  two's-complement sample
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_s  out  1  sign
- out_e  out  EW  exponent
- out_f  out  MW  significand
- out_sat  out  1  result was saturated (qualified by out_valid)
- clr_cnt  in  1  synchronous clear of sat_cnt
- sat_cnt  out  CW  count of saturated results delivered

Behaviour:
- Reset: clears all stage valid bits, out_s/out_e/out_f/out_sat and sat_cnt to 0. A reset mid-operation discards in-flight samples; nothing is emitted afterwards.
- Handshake:
  - A transfer occurs when valid and ready are both high at a rising edge.
  - Each stage holds a valid bit and advances when it is empty or the next stage accepts (bubble-collapsing).
  - in_ready = ~v1 | adv1, combinational from downstream, with no combinational path from in_data.
  - out_valid, once high, stays high and the output data stays stable until out_ready is high.
- Latency: 3 cycles from accepted input to out_valid with out_ready held high; throughput 1 sample per cycle.
- S1, sign/magnitude:
  - s = in_data[DW-1]; mag = |in_data| on DW-1 bits.
  - The most-negative input (magnitude 2^(DW-1)) sets a force-saturate flag.
- S2, leading-zero count: lz = leading zeros of mag over DW-1 bits (fpcvt_lzc).
  - Normalised case, lz <= 2^EW-1: E = 2^EW-1-lz; F = MW bits starting at the leading 1; r = next lower bit.
  - Denormal case, lz > 2^EW-1: E = 0; F = mag[MW-1:0]; r = 0.
- S3, round/normalise:
  - If r = 1, F = F+1.
  - If F carries out: F = 100..0 and E = E+1.
  - If E overflows, or force-saturate is set: E = all ones, F = all ones, sat = 1.
  - The sign passes through; output zero is 0/0/0.
- Saturation counter:
  - sat_cnt increments on each output transfer with out_sat = 1 and saturates at 2^CW-1 (no wrap).
  - clr_cnt has priority over a simultaneous increment; the result is 0.

Optional Feature:
- Macro FPCVT_RNE_EN.
- Defined: S2 also produces a sticky bit (OR of all bits below r). S3 rounds to nearest even: increment iff r & (sticky | F[0]). Carry and saturation rules are unchanged.
- Undefined: round-half-up on r alone, as above; no sticky logic is built.

Decomposition:
- Package fpcvt_pkg holds:
  - the derived constants EMAX = 2^EW-1 and LZW = clog2(DW);
  - the stage payload struct types (s, mag/F, E, r, sticky, sat flag);
  - an exponent/significand width-check function.
- Sub-module fpcvt_lzc: parametrised combinational leading-zero counter, width DW-1, output LZW bits, all-zero input returns DW-1.

Test Plan:
- Defaults, out_ready=1, stream 0, 2, 31 back-to-back -> 0/000/00000, 0/000/00010, 0/000/11111 on consecutive cycles starting at cycle 3; in_ready stays 1.
- Rounding: 0x06C, 0x06D, 0x06E, 0x06F -> 0/010/11011, 0/010/11011, 0/010/11100, 0/010/11100 (with FPCVT_RNE_EN, 0x06E -> 0/010/11100).
- Mantissa carry: 0x0FD -> 0/100/10000; 0x03F -> 0/010/10000.
- Negative and saturation:
  - 0x1E5A -> 1/100/11010; 0x1FFF -> 1/000/00001.
  - 0x1000, 0x0FEA, 0x1007 -> 1/111/11111, 0/111/11111, 1/111/11111, each with out_sat=1; sat_cnt reaches 3.
- Backpressure:
  - Hold out_ready=0 for 5 cycles while feeding 4 samples. Pipeline fills 3 deep and in_ready drops. Outputs stay stable.
  - On release, results emerge in order with no loss or duplication.
- Reset mid-stream with 3 samples in flight -> out_valid=0 next cycle, sat_cnt=0, no stale outputs. clr_cnt asserted on a saturating transfer cycle -> sat_cnt=0.
